ram_sp_be_init: RTL and testbench

- Parametrised single-port synchronous RAM; successor to the fixed 16x8 RAM.
- Adds a valid/ready request handshake, per-byte write enables, and a registered read with a valid strobe.
- Clears memory sequentially, one word per cycle, after reset or on a clear request, instead of in a single cycle.
- Sits behind register-file and buffer controllers in the datapath.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_init_ctrl.sv | 52 +++++
 rtl/ram_sp_be_init.sv | 123 ++++++++++++
 tb/tb_ram_sp_be_init.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable RAM with sequential clear.
// Optional per-byte parity is enabled by defining RAM_PARITY_EN.
package ram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Even parity: the stored bit makes the byte plus parity bit have an even number of ones.
    function automatic logic even_par(input logic [BYTE_W-1:0] i_byte);
        return ^i_byte;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear sequencer: walks every word once after reset or a clear request,
// then holds in RUN. State is exposed so checkers can bind to it.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output state_e            o_state,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_init_done
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_clr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_next_state;
            // Pointer wraps to zero on the last clear write, ready for the next clear.
            if (r_state == ST_INIT) begin
                r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
            end else if (i_clr) begin
                r_clr_ptr <= '0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (r_clr_ptr == '1) w_next_state = ST_RUN;
            ST_RUN:  if (i_clr)           w_next_state = ST_INIT;
            default:                      w_next_state = ST_INIT;
        endcase
    end

    always_comb begin
        o_state     = r_state;
        o_clr_we    = (r_state == ST_INIT);
        o_clr_addr  = r_clr_ptr;
        o_init_done = (r_state == ST_RUN);
    end

endmodule

// File: rtl/ram_sp_be_init.sv
// Single-port RAM with byte enables, registered read and sequential clear.
// Define RAM_PARITY_EN to store one even-parity bit per byte and flag read errors.
module ram_sp_be_init
    import ram_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    input  logic [DATA_W/BYTE_W-1:0] req_be,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_perr,
    output logic                     init_done
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / BYTE_W;

    // Handshake: a request is taken on a rising edge where req_valid and
    // req_ready are both high; req_ready depends only on state and clr.
    state_e            w_state;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_init_done;
    logic              w_accept;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_perr;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_perr;

    ram_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (clr),
        .o_state     (w_state),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_init_done (w_init_done)
    );

    assign req_ready = (w_state == ST_RUN) && !clr;
    assign w_accept  = req_valid && req_ready && !rst;
    assign w_wr_acc  = w_accept && req_we;
    assign w_rd_acc  = w_accept && !req_we;

    always_ff @(posedge clk) begin
        if (w_clr_we && !rst) begin
            r_mem[w_clr_addr] <= INIT_VAL;
        end else if (w_wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr][b*BYTE_W +: BYTE_W] <= req_wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];

    function automatic logic [NB-1:0] par_vec(input logic [DATA_W-1:0] i_word);
        logic [NB-1:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            v[b] = even_par(i_word[b*BYTE_W +: BYTE_W]);
        end
        return v;
    endfunction

    // Parity bits follow the data bytes exactly, including masked writes.
    always_ff @(posedge clk) begin
        if (w_clr_we && !rst) begin
            r_par[w_clr_addr] <= par_vec(INIT_VAL);
        end else if (w_wr_acc) begin
            for (int b = 0; b < NB; b++) begin
                if (req_be[b]) begin
                    r_par[req_addr][b] <= even_par(req_wdata[b*BYTE_W +: BYTE_W]);
                end
            end
        end
    end

    assign w_perr = |(par_vec(r_mem[req_addr]) ^ r_par[req_addr]);
`else
    assign w_perr = 1'b0;
`endif

    // A read accepted on the same edge as reset is dropped by the reset branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_perr  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_rd_perr  <= w_rd_acc && w_perr;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[req_addr];
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign rd_perr   = r_rd_perr;
    assign init_done = w_init_done;

endmodule

// File: tb/tb_ram_sp_be_init.sv
// Bench for ram_sp_be_init (DATA_W=32, ADDR_W=4): directed table, corner sequences,
// and random traffic against an array-based reference model.
module tb_ram_sp_be_init;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_perr;
    logic        init_done;

    ram_sp_be_init #(
        .DATA_W   (32),
        .ADDR_W   (4),
        .INIT_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_perr   (rd_perr),
        .init_done (init_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_mem [16];
    logic [3:0]  m_bad [16];
    bit          m_run   = 1'b0;
    int          m_left  = 16;
    logic [32:0] exp_q [$];
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_mem[i] = 32'h0;
            m_bad[i] = 4'h0;
        end
        m_run  = 1'b0;
        m_left = 16;
    endtask

    // driver: one clock cycle, called at a falling edge
    task automatic step(input logic v, input logic we, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic c, input logic r);
        logic        acc_rd;
        logic [32:0] e;
        rst = r; clr = c; req_valid = v; req_we = we;
        req_addr = a; req_wdata = d; req_be = be;
        #1;
        if (!r) check("req_ready", {63'h0, req_ready}, {63'h0, (m_run && !c)});
        acc_rd = 1'b0;
        if (r) begin
            model_clear();
            last_rd = 32'h0;
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) m_run = 1'b1;
        end else if (c) begin
            model_clear();
        end else if (v) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        m_mem[a][i*8 +: 8] = d[i*8 +: 8];
                        m_bad[a][i] = 1'b0;
                    end
                end
            end else begin
                acc_rd = 1'b1;
                exp_q.push_back({|m_bad[a], m_mem[a]});
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("rd_valid", {63'h0, rd_valid}, {63'h0, acc_rd});
        check("init_done", {63'h0, init_done}, {63'h0, m_run});
        if (acc_rd) begin
            e = exp_q.pop_front();
            check("rd_data", {32'h0, rd_data}, {32'h0, e[31:0]});
            check("rd_perr", {63'h0, rd_perr}, {63'h0, e[32]});
            last_rd = e[31:0];
        end else begin
            check("rd_data_hold", {32'h0, rd_data}, {32'h0, last_rd});
            check("rd_perr_idle", {63'h0, rd_perr}, 64'h0);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    // counts cycles until init_done, optionally holding a write request
    task automatic count_init(input logic hold_wr, output int n);
        n = 0;
        while (!init_done && n < 40) begin
            step(hold_wr, 1'b1, 4'h3, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0);
            n++;
        end
    endtask

    vec_t tbl [10];
    int   n;
    logic exp_p;

    initial begin
        tbl[0] = '{1'b1, 4'd3,  32'hDEAD_BEEF, 4'hF, 32'h0};
        tbl[1] = '{1'b0, 4'd3,  32'h0,         4'h0, 32'hDEAD_BEEF};
        tbl[2] = '{1'b1, 4'd3,  32'h1122_3344, 4'h5, 32'h0};
        tbl[3] = '{1'b0, 4'd3,  32'h0,         4'h0, 32'hDE22_BE44};
        tbl[4] = '{1'b1, 4'd15, 32'hA5A5_A5A5, 4'hF, 32'h0};
        tbl[5] = '{1'b0, 4'd15, 32'h0,         4'h0, 32'hA5A5_A5A5};
        tbl[6] = '{1'b0, 4'd0,  32'h0,         4'h0, 32'h0};
        tbl[7] = '{1'b1, 4'd7,  32'h1234_5678, 4'h0, 32'h0};
        tbl[8] = '{1'b0, 4'd7,  32'h0,         4'h0, 32'h0};
        tbl[9] = '{1'b0, 4'd3,  32'h0,         4'h0, 32'hDE22_BE44};

        // reset for two cycles, then the clear must take exactly 16 cycles
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        check("rst_rd_data", {32'h0, rd_data}, 64'h0);
        check("rst_init_done", {63'h0, init_done}, 64'h0);
        count_init(1'b1, n);
        check("init_len", n, 16);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i));
            check("init_zero", {32'h0, rd_data}, 64'h0);
        end

        // directed table, applied back to back
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 1'b0, 1'b0);
            if (!tbl[i].we) check("tbl_data", {32'h0, rd_data}, {32'h0, tbl[i].exp_data});
        end

        // clr together with a write: write dropped, ready low 17 cycles
        step(1'b1, 1'b1, 4'h3, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
        count_init(1'b1, n);
        check("clr_ready_low", n + 1, 17);
        rd(4'h3);
        check("clr_addr3", {32'h0, rd_data}, 64'h0);

        // reset in the middle of a clear restarts it
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) idle();
        step(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        count_init(1'b0, n);
        check("rst_mid_clear", n, 16);

        // corrupt one stored bit behind the RAM's back
        step(1'b1, 1'b1, 4'h5, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b0);
        dut.r_mem[5][0] = ~dut.r_mem[5][0];
        m_mem[5][0] = ~m_mem[5][0];
`ifdef RAM_PARITY_EN
        m_bad[5][0] = 1'b1;
        exp_p = 1'b1;
`else
        exp_p = 1'b0;
`endif
        rd(4'h5);
        check("perr_flip", {63'h0, rd_perr}, {63'h0, exp_p});
        check("perr_data", {32'h0, rd_data}, 64'h0F0F_0F0E);
        step(1'b1, 1'b1, 4'h5, 32'h0000_00FF, 4'h1, 1'b0, 1'b0);
        rd(4'h5);
        check("perr_repaired", {63'h0, rd_perr}, 64'h0);

        // random traffic with occasional clear and reset
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
